uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive block, the receive-side counterpart to the team's `transmitter`. It recovers 8-bit frames from the asynchronous `UART_RX` line using 16× oversampling and mid-bit sampling. Each good byte is presented on `RX_DATA` with a one-cycle `RX_STATUS` strobe, and each bad frame raises a one-cycle `RX_ERR` strobe. The block sits between the board RX pin and the byte-consuming logic.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and at least 4.
- `MSB_FIRST`, default 1: 1 means the first data bit lands in `RX_DATA[7]`, matching `transmitter`. 0 means the first data bit lands in `RX_DATA[0]`.

Ports:
- `clk`, input, 1 bit: the single clock. All logic is on the rising edge.
- `rst_n`, input, 1 bit: reset, synchronous and active-low.
- `UART_RX`, input, 1 bit: asynchronous serial line. Idles high.
- `RX_DATA`, output, 8 bits: last good byte. Held until the next good frame.
- `RX_STATUS`, output, 1 bit: one-cycle pulse marking that a new byte is valid on `RX_DATA`.
- `RX_ERR`, output, 1 bit: one-cycle pulse on a framing error.
- `RX_BUSY`, output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** `UART_RX` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Prescaler.**
  - `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, integer truncation, minimum 1.
  - The counter runs 0..DIV-1 and emits `tick` when it equals DIV-1.
  - The counter is cleared on entry to START, so tick phase aligns to the start edge.
- **Tick counter.**
  - `tcnt`, width clog2(OVERSAMPLE), counts ticks within a bit.
  - `bcnt`, 3 bits, is the data-bit index.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HI.
  - **IDLE:** when `rx_s`==0, go to START and clear the prescaler and `tcnt`.
  - **START:** at `tick` with `tcnt`==OVERSAMPLE/2-1 (mid start bit), sample `rx_s`.
    - If 0, go to DATA with `tcnt`=0 and `bcnt`=0.
    - If 1, treat as a glitch and return to IDLE. No strobe.
  - **DATA:** at `tick` with `tcnt`==OVERSAMPLE-1, sample `rx_s` into the shift register.
    - With `MSB_FIRST`=1, shift left and insert at bit 0. With `MSB_FIRST`=0, shift right and insert at bit 7.
    - Increment `bcnt`. After bit 7, go to STOP.
  - **STOP:** at `tick` with `tcnt`==OVERSAMPLE-1, sample `rx_s`.
    - If 1: load `RX_DATA` from the shift register, pulse `RX_STATUS` for 1 cycle, go to IDLE.
    - If 0: pulse `RX_ERR` for 1 cycle, leave `RX_DATA` unchanged, go to WAIT_HI.
  - **WAIT_HI:** stay until `rx_s`==1, then go to IDLE. This covers a break or a stuck-low line.
- `RX_STATUS` and `RX_ERR` are never high in the same cycle.
- Reset in mid-frame aborts the frame with no strobe. On the first cycle after `rst_n` deasserts, the FSM is in IDLE with the synchronizer at 1.
  - If the line is still low at that point (mid-frame), the next falling edge seen is treated as a start bit. No resynchronization beyond that is required.

## Timing
- **Reset values:** `RX_DATA`=8'h00, `RX_STATUS`=0, `RX_ERR`=0, `RX_BUSY`=0, FSM=IDLE, shift register=0, counters=0.
- **Cycle 0 definition:** the edge at which the first synchronizer flop captures `UART_RX`=0.
- **Event timing from cycle 0:**
  - START entered at cycle 2.
  - Start sample at cycle 2 + (OVERSAMPLE/2)·DIV.
  - Data bit k (k=0..7) sampled at cycle 2 + (OVERSAMPLE/2 + OVERSAMPLE·(k+1))·DIV.
  - Stop sample at cycle 2 + (OVERSAMPLE/2 + 9·OVERSAMPLE)·DIV.
  - `RX_STATUS` or `RX_ERR` is high in the following cycle.
- **Example:** with OVERSAMPLE=16 and DIV=1, the strobe is high at cycle 155.
- **Back-to-back frames:** a new start edge is accepted the cycle after return to IDLE. Frames with a single stop bit and zero idle time must be received with no loss.
- `RX_BUSY` goes high in the cycle START is entered and low in the cycle IDLE is re-entered.
- **Throughput:** no back-pressure. The consumer must take `RX_DATA` before the next `RX_STATUS`, and `RX_DATA` stays stable for at least one frame time.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1, 16 clk/bit).
- **Single frame:** reset, then drive 0x A5 MSB-first (start 0, bits 1,0,1,0,0,1,0,1, stop 1). Required: `RX_STATUS` pulses once at cycle 155, `RX_DATA`=8'hA5, `RX_ERR` stays 0.
- **LSB-first:** with `MSB_FIRST`=0, drive 0x3C LSB-first. Required: `RX_DATA`=8'h3C, one `RX_STATUS` pulse.
- **Back-to-back:** drive 0x00, 0xFF, 0x81 with no idle gap. Required: three `RX_STATUS` pulses exactly 160 cycles apart, carrying the three values in order.
- **Framing error:** drive 0x55 with stop bit 0, holding the line low for 40 more cycles, then high, then a good 0x12. Required: `RX_ERR` pulses at cycle 155, `RX_DATA` stays at its prior value, the FSM stays in WAIT_HI until the line goes high, then 0x12 is received correctly.
- **Glitch rejection:** drive a 4-cycle low pulse on an idle line. Required: FSM returns to IDLE at cycle 10 with no strobe.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 for 3 cycles. Required: all outputs at reset values the cycle after the reset edge, no strobe, and a subsequent clean 0x7E is received.

Source files
------------

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8-bit UART receiver with 16x (configurable) oversampling and
//                mid-bit sampling. Good bytes are presented on RX_DATA with a
//                one-cycle RX_STATUS strobe; bad stop bits give a one-cycle
//                RX_ERR strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int MSB_FIRST  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_ERR,
    output logic       RX_BUSY
);

    localparam int c_DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_PCNT_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_TCNT_W  = $clog2(OVERSAMPLE);

    localparam logic [c_PCNT_W-1:0] c_PCNT_MAX  = c_PCNT_W'(c_DIV - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_HALF = c_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(OVERSAMPLE - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_DATA    = 3'd2;
    localparam logic [2:0] c_STOP    = 3'd3;
    localparam logic [2:0] c_WAIT_HI = 3'd4;

    logic                r_sync1;
    logic                r_rx_s;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic [2:0]          r_state;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [2:0]          r_bcnt;
    logic [7:0]          r_shift;

    logic                w_tick;
    logic                w_pclr;
    logic [7:0]          w_shift_in;
    logic [2:0]          w_state_nxt;
    logic [c_TCNT_W-1:0] w_tcnt_nxt;
    logic [2:0]          w_bcnt_nxt;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          w_data_nxt;
    logic                w_status_nxt;
    logic                w_err_nxt;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_rx_s  <= r_sync1;
        end
    end

    // Oversampling prescaler; cleared on start detect so ticks align to the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (w_pclr || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign w_tick  = (r_pcnt == c_PCNT_MAX);
    assign RX_BUSY = (r_state != c_IDLE);

    // Bit order selects which end of the shift register receives the new bit.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_in = {r_shift[6:0], r_rx_s};
        end else begin : g_lsb_first
            assign w_shift_in = {r_rx_s, r_shift[7:1]};
        end
    endgenerate

    // FSM state, counters, shift register and output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_shift   <= '0;
            RX_DATA   <= '0;
            RX_STATUS <= 1'b0;
            RX_ERR    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_shift   <= w_shift_nxt;
            RX_DATA   <= w_data_nxt;
            RX_STATUS <= w_status_nxt;
            RX_ERR    <= w_err_nxt;
        end
    end

    // Next-state and output decode; counters only move on prescaler ticks.
    always_comb begin
        w_state_nxt  = r_state;
        w_tcnt_nxt   = r_tcnt;
        w_bcnt_nxt   = r_bcnt;
        w_shift_nxt  = r_shift;
        w_data_nxt   = RX_DATA;
        w_status_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_pclr       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = c_START;
                    w_tcnt_nxt  = '0;
                    w_pclr      = 1'b1;
                end
            end
            c_START: begin
                if (w_tick) begin
                    if (r_tcnt == c_TCNT_HALF) begin
                        if (!r_rx_s) begin
                            w_state_nxt = c_DATA;
                            w_tcnt_nxt  = '0;
                            w_bcnt_nxt  = '0;
                        end else begin
                            // Start bit vanished before mid-bit: a glitch.
                            w_state_nxt = c_IDLE;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    if (r_tcnt == c_TCNT_LAST) begin
                        w_tcnt_nxt  = '0;
                        w_shift_nxt = w_shift_in;
                        w_bcnt_nxt  = r_bcnt + 1'b1;
                        if (r_bcnt == 3'd7) begin
                            w_state_nxt = c_STOP;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            c_STOP: begin
                if (w_tick) begin
                    if (r_tcnt == c_TCNT_LAST) begin
                        w_tcnt_nxt = '0;
                        if (r_rx_s) begin
                            w_data_nxt   = r_shift;
                            w_status_nxt = 1'b1;
                            w_state_nxt  = c_IDLE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = c_WAIT_HI;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
            end
            c_WAIT_HI: begin
                // Hold off on a break or stuck-low line until it returns high.
                if (r_rx_s) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Directed scoreboard bench for uart_receiver (DIV=1, 16x).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_CLK_FREQ = 1_600_000;
    localparam int c_BAUD     = 100_000;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       status_a, status_b, err_a, err_b, busy_a, busy_b;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         n_status_a = 0;
    int         n_err_a = 0;
    int         n_status_b = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       q_a[$];
    exp_t       q_b[$];
    exp_t       q_err[$];

    uart_receiver #(
        .CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .OVERSAMPLE(16), .MSB_FIRST(1)
    ) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .UART_RX(line_a), .RX_DATA(data_a),
        .RX_STATUS(status_a), .RX_ERR(err_a), .RX_BUSY(busy_a)
    );

    uart_receiver #(
        .CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .OVERSAMPLE(16), .MSB_FIRST(0)
    ) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .UART_RX(line_b), .RX_DATA(data_b),
        .RX_STATUS(status_b), .RX_ERR(err_b), .RX_BUSY(busy_b)
    );

    always #5 clk = ~clk;

    // Edge counter used as the time base for expected strobe cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance whole clocks; call and return at posedge+1.
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stop at the first falling edge where the edge counter has reached target.
    task automatic wait_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    // Drive one 10-bit frame (16 clocks per bit) and queue the expected strobe.
    task automatic send(input logic [7:0] d, input bit stop, input bit lsb, input bit on_b);
        logic [9:0] seq;
        exp_t       e;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = lsb ? d[i] : d[7-i];
        seq[9] = stop;
        e.data = d;
        e.at   = cyc + 155;
        if (!stop)     q_err.push_back(e);
        else if (on_b) q_b.push_back(e);
        else           q_a.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (on_b) line_b = seq[i];
            else      line_a = seq[i];
            ticks(16);
        end
    endtask

    // Scoreboard for the MSB-first receiver.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) last_good = 8'h00;
        if (status_a || err_a) check("a_excl", {31'd0, status_a & err_a}, 32'd0);
        if (status_a) begin
            n_status_a++;
            check("a_status_expected", {31'd0, q_a.size() != 0}, 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a_data", {24'd0, data_a}, {24'd0, e.data});
                check("a_status_cycle", cyc, e.at);
                last_good = e.data;
            end
        end
        if (err_a) begin
            n_err_a++;
            check("a_err_expected", {31'd0, q_err.size() != 0}, 32'd1);
            if (q_err.size() != 0) begin
                e = q_err.pop_front();
                check("a_err_cycle", cyc, e.at);
            end
            check("a_data_hold", {24'd0, data_a}, {24'd0, last_good});
        end
    end

    // Scoreboard for the LSB-first receiver.
    always @(negedge clk) begin
        exp_t e;
        if (err_b) check("b_err", {31'd0, err_b}, 32'd0);
        if (status_b) begin
            n_status_b++;
            check("b_status_expected", {31'd0, q_b.size() != 0}, 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b_data", {24'd0, data_b}, {24'd0, e.data});
                check("b_status_cycle", cyc, e.at);
            end
        end
    end

    // Directed test sequence.
    initial begin
        int n;
        int r;

        // Reset values
        ticks(4);
        @(negedge clk);
        check("rst_data", {24'd0, data_a}, 32'h00);
        check("rst_status", {31'd0, status_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_data_b", {24'd0, data_b}, 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(5);

        // Single MSB-first frame
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("single_data", {24'd0, data_a}, 32'hA5);
        check("single_busy", {31'd0, busy_a}, 32'd0);

        // LSB-first frame on the second receiver
        send(8'h3C, 1'b1, 1'b1, 1'b1);
        ticks(20);
        check("lsb_data", {24'd0, data_b}, 32'h3C);

        // Back-to-back frames, no idle gap
        send(8'h00, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'h81, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("b2b_last", {24'd0, data_a}, 32'h81);

        // Framing error, line held low, then recovery
        send(8'h55, 1'b0, 1'b0, 1'b0);
        line_a = 1'b0;
        ticks(40);
        @(negedge clk);
        check("wait_hi_busy", {31'd0, busy_a}, 32'd1);
        check("wait_hi_data", {24'd0, data_a}, 32'h81);
        @(posedge clk);
        #1;
        line_a = 1'b1;
        n = cyc;
        wait_neg(n + 2);
        check("wait_hi_still", {31'd0, busy_a}, 32'd1);
        wait_neg(n + 3);
        check("wait_hi_exit", {31'd0, busy_a}, 32'd0);
        @(posedge clk);
        #1;
        ticks(10);
        send(8'h12, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("recover_data", {24'd0, data_a}, 32'h12);

        // Glitch rejection: 4-cycle low pulse
        n = cyc;
        line_a = 1'b0;
        ticks(4);
        line_a = 1'b1;
        wait_neg(n + 3);
        check("glitch_busy_start", {31'd0, busy_a}, 32'd1);
        wait_neg(n + 10);
        check("glitch_busy_mid", {31'd0, busy_a}, 32'd1);
        wait_neg(n + 11);
        check("glitch_idle", {31'd0, busy_a}, 32'd0);
        @(posedge clk);
        #1;
        ticks(20);

        // Reset during data bit 4 of 0x0F (line high from bit 4 onward)
        line_a = 1'b0;
        ticks(16 + 64);
        line_a = 1'b1;
        ticks(8);
        rst_n = 1'b0;
        r = cyc;
        wait_neg(r + 1);
        check("mid_rst_data", {24'd0, data_a}, 32'h00);
        check("mid_rst_status", {31'd0, status_a}, 32'd0);
        check("mid_rst_err", {31'd0, err_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        @(posedge clk);
        #1;
        ticks(1);
        rst_n = 1'b1;
        ticks(8 + 48 + 16 + 10);
        check("post_rst_idle", {31'd0, busy_a}, 32'd0);
        send(8'h7E, 1'b1, 1'b0, 1'b0);
        ticks(20);
        check("post_rst_data", {24'd0, data_a}, 32'h7E);

        // Final accounting
        ticks(50);
        check("q_a_empty", q_a.size(), 32'd0);
        check("q_b_empty", q_b.size(), 32'd0);
        check("q_err_empty", q_err.size(), 32'd0);
        check("n_status_a", n_status_a, 32'd6);
        check("n_err_a", n_err_a, 32'd1);
        check("n_status_b", n_status_b, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
